xillybus_mem8_regbank: RTL and testbench

//  Register bank on the bus_clk side of the Xillybus core's 32-byte user_mem_8 seekable stream.
//  - Consumes user_w_mem_8_* (writes) and produces user_r_mem_8_* (reads).
//  - Exposes shield control bits and LEDs, synchronised GPIO inputs, sticky edge flags and an irq.

---
 rtl/xillybus_mem8_regbank.sv | 129 ++++++++++++
 tb/tb_xillybus_mem8_regbank.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_mem8_regbank.sv
// Register bank behind the Xillybus 32-byte user_mem_8 seekable stream (bus_clk domain).
// Optional 0x14 rising-edge counter on gpio bit 0 is built when MEM8_EDGE_CNT_EN is defined.
module xillybus_mem8_regbank #(
    parameter logic [7:0] VERSION     = 8'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       bus_clk,
    input  logic       pcie_perstn,
    input  logic       user_w_mem_8_wren,
    input  logic [7:0] user_w_mem_8_data,
    output logic       user_w_mem_8_full,
    input  logic       user_w_mem_8_open,
    input  logic       user_r_mem_8_rden,
    output logic [7:0] user_r_mem_8_data,
    output logic       user_r_mem_8_empty,
    output logic       user_r_mem_8_eof,
    input  logic       user_r_mem_8_open,
    input  logic [4:0] user_mem_8_addr,
    input  logic       user_mem_8_addr_update,
    input  logic [7:0] gpio_in,
    output logic [7:0] ctrl_out,
    output logic [3:0] led_out,
    output logic       irq
);

    localparam logic [4:0] ADDR_GPIO  = 5'h10;
    localparam logic [4:0] ADDR_RISE  = 5'h11;
    localparam logic [4:0] ADDR_FALL  = 5'h12;
    localparam logic [4:0] ADDR_VER   = 5'h13;
    localparam logic [4:0] ADDR_ECNT  = 5'h14;

    logic [7:0] regs [16];
    logic [7:0] sync_p [SYNC_STAGES];
    logic [7:0] gs;
    logic [7:0] gs_d;
    logic [7:0] rise_flags;
    logic [7:0] fall_flags;
    logic [7:0] rise_ev;
    logic [7:0] fall_ev;
    logic [7:0] rise_clr;
    logic [7:0] fall_clr;
    logic [7:0] rd_val;
    logic [7:0] rd_data_p1;
    logic [7:0] cnt_rd;
    logic       irq_p1;
    logic       wr_scratch;
    logic       unused_inputs;

    assign unused_inputs = user_w_mem_8_open ^ user_r_mem_8_open ^ user_mem_8_addr_update;

    assign user_w_mem_8_full  = 1'b0;
    assign user_r_mem_8_empty = 1'b0;
    assign user_r_mem_8_eof   = 1'b0;

    assign gs         = sync_p[SYNC_STAGES-1];
    assign rise_ev    = gs & ~gs_d;
    assign fall_ev    = ~gs & gs_d;
    assign wr_scratch = user_w_mem_8_wren && !user_mem_8_addr[4];
    assign rise_clr   = (user_w_mem_8_wren && user_mem_8_addr == ADDR_RISE) ? user_w_mem_8_data : 8'h00;
    assign fall_clr   = (user_w_mem_8_wren && user_mem_8_addr == ADDR_FALL) ? user_w_mem_8_data : 8'h00;

    // Synchroniser, edge detect, sticky flags and scratch registers
    always_ff @(posedge bus_clk or negedge pcie_perstn) begin
        if (!pcie_perstn) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= 8'h00;
            gs_d       <= 8'h00;
            rise_flags <= 8'h00;
            fall_flags <= 8'h00;
            rd_data_p1 <= 8'h00;
            irq_p1     <= 1'b0;
        end else begin
            sync_p[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            gs_d <= gs;
            // A new edge in the same cycle as its clear keeps the flag set
            rise_flags <= (rise_flags & ~rise_clr) | rise_ev;
            fall_flags <= (fall_flags & ~fall_clr) | fall_ev;
            if (wr_scratch)
                regs[user_mem_8_addr[3:0]] <= user_w_mem_8_data;
            if (user_r_mem_8_rden)
                rd_data_p1 <= rd_val;
            irq_p1 <= |(rise_flags & regs[2]);
        end
    end

`ifdef MEM8_EDGE_CNT_EN
    logic [7:0] edge_cnt;
    logic       cnt_clr;

    assign cnt_clr = user_w_mem_8_wren && user_mem_8_addr == ADDR_ECNT;

    always_ff @(posedge bus_clk or negedge pcie_perstn) begin
        if (!pcie_perstn)
            edge_cnt <= 8'h00;
        else if (cnt_clr)
            edge_cnt <= {7'd0, rise_ev[0]};
        else
            edge_cnt <= edge_cnt + {7'd0, rise_ev[0]};
    end

    assign cnt_rd = edge_cnt;
`else
    assign cnt_rd = 8'h00;
`endif

    // Read mux sees register state before this cycle's write lands
    always_comb begin
        rd_val = 8'h00;
        if (!user_mem_8_addr[4]) begin
            rd_val = regs[user_mem_8_addr[3:0]];
        end else begin
            case (user_mem_8_addr)
                ADDR_GPIO: rd_val = gs;
                ADDR_RISE: rd_val = rise_flags;
                ADDR_FALL: rd_val = fall_flags;
                ADDR_VER:  rd_val = VERSION;
                ADDR_ECNT: rd_val = cnt_rd;
                default:   rd_val = 8'h00;
            endcase
        end
    end

    assign user_r_mem_8_data = rd_data_p1;
    assign ctrl_out          = regs[0];
    assign led_out           = regs[1][3:0];
    assign irq               = irq_p1;

endmodule

// File: tb/tb_xillybus_mem8_regbank.sv
// Directed and randomized checks of xillybus_mem8_regbank against a behavioural register-map model.
// Expectations for 0x14 follow MEM8_EDGE_CNT_EN as seen by this compile.
module tb_xillybus_mem8_regbank;

    localparam int S = 2;

    logic       bus_clk;
    logic       pcie_perstn;
    logic       wren;
    logic [7:0] wdata;
    logic       full;
    logic       rden;
    logic [7:0] rdata;
    logic       empty;
    logic       eof;
    logic [4:0] addr;
    logic [7:0] gpio_in;
    logic [7:0] ctrl_out;
    logic [3:0] led_out;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_regs [16];
    logic [7:0] m_gs;
    logic [7:0] m_rise;
    logic [7:0] m_fall;
    logic [7:0] m_cnt;

    xillybus_mem8_regbank #(.VERSION(8'h01), .SYNC_STAGES(S)) dut (
        .bus_clk                (bus_clk),
        .pcie_perstn            (pcie_perstn),
        .user_w_mem_8_wren      (wren),
        .user_w_mem_8_data      (wdata),
        .user_w_mem_8_full      (full),
        .user_w_mem_8_open      (1'b1),
        .user_r_mem_8_rden      (rden),
        .user_r_mem_8_data      (rdata),
        .user_r_mem_8_empty     (empty),
        .user_r_mem_8_eof       (eof),
        .user_r_mem_8_open      (1'b1),
        .user_mem_8_addr        (addr),
        .user_mem_8_addr_update (1'b0),
        .gpio_in                (gpio_in),
        .ctrl_out               (ctrl_out),
        .led_out                (led_out),
        .irq                    (irq)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_gs   = 8'h00;
        m_rise = 8'h00;
        m_fall = 8'h00;
        m_cnt  = 8'h00;
    endtask

    function automatic logic [7:0] exp_read(input logic [4:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a < 5'h10) v = m_regs[a[3:0]];
        else if (a == 5'h10) v = m_gs;
        else if (a == 5'h11) v = m_rise;
        else if (a == 5'h12) v = m_fall;
        else if (a == 5'h13) v = 8'h01;
`ifdef MEM8_EDGE_CNT_EN
        else if (a == 5'h14) v = m_cnt;
`endif
        return v;
    endfunction

    function automatic logic exp_irq();
        return |(m_rise & m_regs[2]);
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [7:0] d);
        if (a < 5'h10) m_regs[a[3:0]] = d;
        else if (a == 5'h11) m_rise = m_rise & ~d;
        else if (a == 5'h12) m_fall = m_fall & ~d;
        else if (a == 5'h14) m_cnt = 8'h00;
    endtask

    task automatic model_gpio(input logic [7:0] v);
        if (v[0] && !m_gs[0]) m_cnt = m_cnt + 8'd1;
        m_rise = m_rise | (v & ~m_gs);
        m_fall = m_fall | (~v & m_gs);
        m_gs   = v;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wren  = 1'b1;
        tick();
        wren  = 1'b0;
        model_write(a, d);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        addr = a;
        rden = 1'b1;
        tick();
        rden = 1'b0;
        d    = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a);
        logic [7:0] d;
        rd(a, d);
        chk(tag, d, exp_read(a));
    endtask

    task automatic set_gpio(input logic [7:0] v);
        gpio_in = v;
        model_gpio(v);
        repeat (S + 2) tick();
    endtask

    // Raise gpio bit 0 so its flag/counter update lands on the same edge as the write
    task automatic edge_collide(input logic [4:0] a, input logic [7:0] d);
        logic [7:0] nv;
        nv = m_gs | 8'h01;
        gpio_in = nv;
        repeat (S) tick();
        wr(a, d);
        model_gpio(nv);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_ctrl"}, ctrl_out, m_regs[0]);
        chk({tag, "_led"}, {4'h0, led_out}, {4'h0, m_regs[1][3:0]});
        chk({tag, "_irq"}, {7'd0, irq}, {7'd0, exp_irq()});
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] nv;
        logic [4:0] ra;
        int         op;

        pcie_perstn = 1'b0;
        wren = 1'b0; rden = 1'b0; wdata = 8'h00; addr = 5'h00; gpio_in = 8'h00;
        model_reset();
        repeat (3) tick();
        pcie_perstn = 1'b1;
        tick();
        chk_outputs("init");

        // Mid-stream asynchronous reset with irq asserted
        wr(5'h00, 8'h5A);
        wr(5'h01, 8'hA5);
        wr(5'h02, 8'hFF);
        set_gpio(8'h01);
        set_gpio(8'h00);
        chk("pre_reset_irq", {7'd0, irq}, 8'h01);
        @(posedge bus_clk);
        #2 pcie_perstn = 1'b0;
        #1;
        model_reset();
        chk("rst_ctrl", ctrl_out, 8'h00);
        chk("rst_led", {4'h0, led_out}, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        tick();
        pcie_perstn = 1'b1;
        rd_chk("rst_rd00", 5'h00);
        rd_chk("rst_rd11", 5'h11);

        // Control and LED writes
        wr(5'h00, 8'h5A);
        chk("ctrl_5a", ctrl_out, 8'h5A);
        wr(5'h01, 8'hA5);
        chk("led_5", {4'h0, led_out}, 8'h05);
        rd(5'h00, d);
        chk("rd00_5a", d, 8'h5A);

        // gpio 0x00 -> 0x81 with exact synchroniser and flag latency
        wr(5'h02, 8'h80);
        gpio_in = 8'h81;
        repeat (S - 1) tick();
        rd(5'h10, d);
        chk("gs_not_yet", d, 8'h00);
        rd(5'h11, d);
        chk("rise_not_yet", d, 8'h00);
        model_gpio(8'h81);
        rd(5'h11, d);
        chk("rise_81", d, 8'h81);
        rd(5'h10, d);
        chk("gs_81", d, 8'h81);
        chk("irq_set", {7'd0, irq}, 8'h01);
        wr(5'h11, 8'h01);
        rd(5'h11, d);
        chk("rise_w1c_80", d, 8'h80);
        chk("irq_still", {7'd0, irq}, 8'h01);
        wr(5'h11, 8'h80);
        chk("irq_lag", {7'd0, irq}, 8'h01);
        tick();
        chk("irq_clr", {7'd0, irq}, 8'h00);

        // Same-cycle W1C vs new rising edge on bit 0
        set_gpio(8'h80);
        wr(5'h11, 8'hFF);
        wr(5'h12, 8'hFF);
        edge_collide(5'h11, 8'h01);
        rd(5'h11, d);
        chk("w1c_vs_set", d, 8'h01);
        rd_chk("fall_model", 5'h12);

        // Same-cycle read and write of a scratch register
        wr(5'h03, 8'h11);
        addr = 5'h03; wdata = 8'h22; wren = 1'b1; rden = 1'b1;
        tick();
        wren = 1'b0; rden = 1'b0;
        chk("rdw_old", rdata, 8'h11);
        model_write(5'h03, 8'h22);
        rd(5'h03, d);
        chk("rdw_new", d, 8'h22);

        // Edge counter: wrap, increment, clear, clear/increment collision
        set_gpio(8'h00);
        wr(5'h14, 8'h5C);
        rd_chk("cnt_clr0", 5'h14);
        for (int i = 0; i < 256; i++) begin
            set_gpio(8'h01);
            set_gpio(8'h00);
        end
        rd(5'h14, d);
        chk("cnt_wrap", d, 8'h00);
        for (int i = 0; i < 3; i++) begin
            set_gpio(8'h01);
            set_gpio(8'h00);
        end
        rd_chk("cnt_3", 5'h14);
        wr(5'h14, 8'hFF);
        rd(5'h14, d);
        chk("cnt_wclr", d, 8'h00);
        edge_collide(5'h14, 8'h00);
        rd_chk("cnt_collide", 5'h14);

        // Constant and unmapped locations
        rd(5'h13, d);
        chk("version", d, 8'h01);
        rd(5'h1F, d);
        chk("rd1f", d, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 3));
            ra = 5'($urandom_range(0, 31));
            if (op == 0 || op == 1) begin
                wr(ra, 8'($urandom));
            end else if (op == 2) begin
                rd_chk("rand_rd", ra);
            end else begin
                nv = 8'($urandom);
                set_gpio(nv);
            end
            tick();
            chk_outputs("rand");
        end
        for (int a = 0; a < 32; a++) rd_chk("sweep", 5'(a));

        chk("full", {7'd0, full}, 8'h00);
        chk("empty", {7'd0, empty}, 8'h00);
        chk("eof", {7'd0, eof}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Tie-offs must never move
    always @(negedge bus_clk) begin
        if (pcie_perstn && (full !== 1'b0 || empty !== 1'b0 || eof !== 1'b0)) begin
            checks++;
            failures++;
            $error("FAIL const_outputs observed=%b%b%b expected=000", full, empty, eof);
        end
    end

endmodule
